// File: rtl/serial_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_receiver_pkg
//   Shared definitions for the 8N1 serial link: frame width and the receive
//   FSM state encoding. The transmitter side uses the same encoding.
// -----------------------------------------------------------------------------
package serial_receiver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/serial_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_receiver_if
//   Bundles the serial line, the consumer read strobe and the parallel byte
//   and status outputs of serial_receiver.
//   slave  : receiver side (drives OUT_*, samples IN_*)
//   master : consumer/line side (drives IN_*, samples OUT_*)
// -----------------------------------------------------------------------------
interface serial_receiver_if;
  import serial_receiver_pkg::*;

  logic                 IN_SERIAL_RX;
  logic                 IN_READ;
  logic [DATA_BITS-1:0] OUT_DATA;
  logic                 OUT_VALID;
  logic                 OUT_OVERRUN;
  logic                 OUT_FRAME_ERR;
  logic                 OUT_BUSY;

  modport slave (
    input  IN_SERIAL_RX, IN_READ,
    output OUT_DATA, OUT_VALID, OUT_OVERRUN, OUT_FRAME_ERR, OUT_BUSY
  );

  modport master (
    output IN_SERIAL_RX, IN_READ,
    input  OUT_DATA, OUT_VALID, OUT_OVERRUN, OUT_FRAME_ERR, OUT_BUSY
  );
endinterface

// File: rtl/serial_receiver_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_receiver_bit_timer
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; clr forces it
//   back to 0 on the next edge.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the bit period
//   tick      : counter is at CLKS_PER_BIT-1 (end of a bit period)
//   half_tick : counter is at HALF_BIT-1 (middle of the start bit)
// -----------------------------------------------------------------------------
module serial_receiver_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic half_tick
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    half_tick = (cnt_q == CNT_W'(HALF_BIT - 1));
    cnt_d     = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   8N1 UART-style receiver (LSB first, start=0, stop=1) on a single clock;
//   the bit period is CLKS_PER_BIT cycles, sampled mid-bit.
//   CLK   : sole clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : IN_SERIAL_RX, IN_READ in; OUT_DATA, OUT_VALID, OUT_OVERRUN,
//           OUT_FRAME_ERR (1-cycle pulse), OUT_BUSY out
// -----------------------------------------------------------------------------
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  serial_receiver_if.slave   bus
);
  logic [1:0]           sync_q, sync_d;
  rx_state_e            state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx, load, tick, half_tick, timer_clr;

  assign rx = sync_q[1];

  // Every state change restarts the bit period, so each state times from 0.
  assign timer_clr = (state_d != state_q);

  serial_receiver_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (CLK),
    .rst       (RESET),
    .clr       (timer_clr),
    .tick      (tick),
    .half_tick (half_tick)
  );

  always_comb begin
    sync_d      = {sync_q[0], bus.IN_SERIAL_RX};
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE:  if (!rx) state_d = ST_START;
      ST_START: begin
        bit_idx_d = '0;
        // Line back high at mid start bit is a glitch, not a frame.
        if (half_tick) state_d = rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (tick) begin
        shreg_d   = {rx, shreg_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
      end
      ST_STOP: if (tick) begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (rx) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: if (rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    data_d    = load ? shreg_q : data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) valid_d = 1'b1;
    else if (bus.IN_READ && valid_q) valid_d = 1'b0;
    // A read in the same cycle as a load consumes the old byte: no overrun.
    if (load && valid_q && !bus.IN_READ) overrun_d = 1'b1;
    else if (bus.IN_READ && valid_q) overrun_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.OUT_DATA      = data_q;
  assign bus.OUT_VALID     = valid_q;
  assign bus.OUT_OVERRUN   = overrun_q;
  assign bus.OUT_FRAME_ERR = frame_err_q;
  assign bus.OUT_BUSY      = (state_q != ST_IDLE);
endmodule
